// File: rtl/adma_as_atx_issue_if.sv
// Bus bundle for the AXI transaction issue stage.
//  master : issue-stage view (takes atx requests, drives AR/AW, sinks B)
//  slave  : environment view (upstream requester plus AXI slave side)
//  Groups the atx request fields, AR/AW address channels, B channel and status outputs.
interface adma_as_atx_issue_if #(
    parameter int unsigned MST_ID_W   = 5,
    parameter int unsigned SRC_ADDR_W = 32,
    parameter int unsigned DST_ADDR_W = 32,
    parameter int unsigned ATX_LEN_W  = 8,
    parameter int unsigned OST_MAX    = 4
);
    localparam int unsigned OST_CNT_W = $clog2(OST_MAX + 1);

    // combined AR+AW request from upstream
    logic [MST_ID_W-1:0]   arid;
    logic [SRC_ADDR_W-1:0] araddr;
    logic [ATX_LEN_W-1:0]  arlen;
    logic [1:0]            arburst;
    logic [MST_ID_W-1:0]   awid;
    logic [DST_ADDR_W-1:0] awaddr;
    logic [ATX_LEN_W-1:0]  awlen;
    logic [1:0]            awburst;
    logic                  atx_vld;
    logic                  atx_rdy;
    logic                  atx_done;

    // AXI AR channel
    logic [MST_ID_W-1:0]   m_arid;
    logic [SRC_ADDR_W-1:0] m_araddr;
    logic [ATX_LEN_W-1:0]  m_arlen;
    logic [1:0]            m_arburst;
    logic                  m_arvalid;
    logic                  m_arready;

    // AXI AW channel
    logic [MST_ID_W-1:0]   m_awid;
    logic [DST_ADDR_W-1:0] m_awaddr;
    logic [ATX_LEN_W-1:0]  m_awlen;
    logic [1:0]            m_awburst;
    logic                  m_awvalid;
    logic                  m_awready;

    // AXI B channel
    logic [MST_ID_W-1:0]   m_bid;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;

    // status
    logic [OST_CNT_W-1:0]  ost_cnt;
    logic                  bresp_err;

    modport master (
        input  arid, araddr, arlen, arburst,
        input  awid, awaddr, awlen, awburst,
        input  atx_vld,
        output atx_rdy, atx_done,
        output m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
        input  m_arready,
        output m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
        input  m_awready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready,
        output ost_cnt, bresp_err
    );

    modport slave (
        output arid, araddr, arlen, arburst,
        output awid, awaddr, awlen, awburst,
        output atx_vld,
        input  atx_rdy, atx_done,
        input  m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
        output m_arready,
        input  m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
        output m_awready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready,
        input  ost_cnt, bresp_err
    );
endinterface

// File: rtl/adma_as_atx_issue.sv
// Downstream issue stage of the AXI transaction request path.
// Accepts one combined AR+AW request, forks it onto the AXI AR and AW channels
// independently, counts outstanding write bursts (bounded by OST_MAX) and pulses
// atx_done (plus bresp_err on a non-OKAY response) one cycle after each B handshake.
// Ports:
//  clk  : clock
//  rst  : synchronous reset, active-high
//  bus  : adma_as_atx_issue_if.master (atx request, AR/AW/B channels, ost_cnt, bresp_err)
// Every output is a flop; atx_rdy and m_bready are registered copies of functions
// of the next state, so they match the same functions of the current state.
module adma_as_atx_issue #(
    parameter int unsigned MST_ID_W   = 5,
    parameter int unsigned SRC_ADDR_W = 32,
    parameter int unsigned DST_ADDR_W = 32,
    parameter int unsigned ATX_LEN_W  = 8,
    parameter int unsigned OST_MAX    = 4
) (
    input logic                 clk,
    input logic                 rst,
    adma_as_atx_issue_if.master bus
);
    localparam int unsigned OST_CNT_W = $clog2(OST_MAX + 1);

    // state registers
    logic                  ar_pend_q, aw_pend_q;
    logic [OST_CNT_W-1:0]  ost_q;
    logic                  rdy_q, bready_q, done_q, err_q;
    logic [MST_ID_W-1:0]   ar_id_q, aw_id_q;
    logic [SRC_ADDR_W-1:0] ar_addr_q;
    logic [DST_ADDR_W-1:0] aw_addr_q;
    logic [ATX_LEN_W-1:0]  ar_len_q, aw_len_q;
    logic [1:0]            ar_burst_q, aw_burst_q;

    // next-state values
    logic                  ar_pend_d, aw_pend_d;
    logic [OST_CNT_W-1:0]  ost_d;
    logic                  rdy_d, bready_d, done_d, err_d;
    logic [MST_ID_W-1:0]   ar_id_d, aw_id_d;
    logic [SRC_ADDR_W-1:0] ar_addr_d;
    logic [DST_ADDR_W-1:0] aw_addr_d;
    logic [ATX_LEN_W-1:0]  ar_len_d, aw_len_d;
    logic [1:0]            ar_burst_d, aw_burst_d;

    // handshake qualifiers
    logic accept, ar_hs, aw_hs, b_hs;

    assign accept = bus.atx_vld & rdy_q;
    assign ar_hs  = ar_pend_q & bus.m_arready;
    assign aw_hs  = aw_pend_q & bus.m_awready;
    assign b_hs   = bus.m_bvalid & bready_q;

    // next-state logic
    always_comb begin
        ar_pend_d  = ar_pend_q;
        aw_pend_d  = aw_pend_q;
        ost_d      = ost_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_burst_d = ar_burst_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_burst_d = aw_burst_q;
        done_d     = b_hs;
        err_d      = b_hs & (bus.m_bresp != 2'b00);

        // AR and AW retire independently
        if (ar_hs) ar_pend_d = 1'b0;
        if (aw_hs) aw_pend_d = 1'b0;

        // accept only happens with both channels idle, so it never races a handshake
        if (accept) begin
            ar_pend_d  = 1'b1;
            aw_pend_d  = 1'b1;
            ar_id_d    = bus.arid;
            ar_addr_d  = bus.araddr;
            ar_len_d   = bus.arlen;
            ar_burst_d = bus.arburst;
            aw_id_d    = bus.awid;
            aw_addr_d  = bus.awaddr;
            aw_len_d   = bus.awlen;
            aw_burst_d = bus.awburst;
        end

        // accept is gated by ost<OST_MAX and b_hs by ost!=0: no overflow/underflow
        unique case ({accept, b_hs})
            2'b10:   ost_d = ost_q + OST_CNT_W'(1);
            2'b01:   ost_d = ost_q - OST_CNT_W'(1);
            default: ost_d = ost_q;
        endcase

        rdy_d    = ~ar_pend_d & ~aw_pend_d & (ost_d < OST_CNT_W'(OST_MAX));
        bready_d = (ost_d != '0);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_pend_q  <= 1'b0;
            aw_pend_q  <= 1'b0;
            ost_q      <= '0;
            rdy_q      <= 1'b1;
            bready_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
        end else begin
            ar_pend_q  <= ar_pend_d;
            aw_pend_q  <= aw_pend_d;
            ost_q      <= ost_d;
            rdy_q      <= rdy_d;
            bready_q   <= bready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_burst_q <= ar_burst_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_burst_q <= aw_burst_d;
        end
    end

    // output mapping
    assign bus.atx_rdy   = rdy_q;
    assign bus.atx_done  = done_q;
    assign bus.bresp_err = err_q;
    assign bus.ost_cnt   = ost_q;
    assign bus.m_bready  = bready_q;

    assign bus.m_arvalid = ar_pend_q;
    assign bus.m_arid    = ar_id_q;
    assign bus.m_araddr  = ar_addr_q;
    assign bus.m_arlen   = ar_len_q;
    assign bus.m_arburst = ar_burst_q;

    assign bus.m_awvalid = aw_pend_q;
    assign bus.m_awid    = aw_id_q;
    assign bus.m_awaddr  = aw_addr_q;
    assign bus.m_awlen   = aw_len_q;
    assign bus.m_awburst = aw_burst_q;
endmodule

// File: tb/tb_adma_as_atx_issue.sv
// Bench for adma_as_atx_issue: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_adma_as_atx_issue;
    localparam int unsigned OST_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    adma_as_atx_issue_if #(.OST_MAX(OST_MAX)) bus ();

    adma_as_atx_issue #(.OST_MAX(OST_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model: what has been handed to us but not yet issued/completed
    bit          mar, maw;      // AR / AW request still waiting for its handshake
    int          mo;            // write bursts issued and not yet answered by B
    bit          mdone, merr;   // completion pulses due this cycle
    logic [4:0]  e_arid, e_awid;
    logic [31:0] e_araddr, e_awaddr;
    logic [7:0]  e_arlen, e_awlen;
    logic [1:0]  e_arburst, e_awburst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mar = 0; maw = 0; mo = 0; mdone = 0; merr = 0;
        e_arid = '0; e_awid = '0; e_araddr = '0; e_awaddr = '0;
        e_arlen = '0; e_awlen = '0; e_arburst = '0; e_awburst = '0;
    endtask

    // compare this cycle's outputs, advance the model by this cycle's inputs, then clock
    task automatic cyc();
        bit exp_rdy, acc, bh;
        exp_rdy = !mar && !maw && (mo < int'(OST_MAX));
        chk("atx_rdy",   32'(bus.atx_rdy),   32'(exp_rdy));
        chk("m_arvalid", 32'(bus.m_arvalid), 32'(mar));
        chk("m_awvalid", 32'(bus.m_awvalid), 32'(maw));
        chk("m_bready",  32'(bus.m_bready),  32'(mo != 0));
        chk("ost_cnt",   32'(bus.ost_cnt),   32'(mo));
        chk("atx_done",  32'(bus.atx_done),  32'(mdone));
        chk("bresp_err", 32'(bus.bresp_err), 32'(merr));
        if (mar) begin
            chk("m_arid",    32'(bus.m_arid),    32'(e_arid));
            chk("m_araddr",  bus.m_araddr,       e_araddr);
            chk("m_arlen",   32'(bus.m_arlen),   32'(e_arlen));
            chk("m_arburst", 32'(bus.m_arburst), 32'(e_arburst));
        end
        if (maw) begin
            chk("m_awid",    32'(bus.m_awid),    32'(e_awid));
            chk("m_awaddr",  bus.m_awaddr,       e_awaddr);
            chk("m_awlen",   32'(bus.m_awlen),   32'(e_awlen));
            chk("m_awburst", 32'(bus.m_awburst), 32'(e_awburst));
        end

        acc   = bus.atx_vld && exp_rdy;
        bh    = bus.m_bvalid && (mo != 0);
        mdone = bh;
        merr  = bh && (bus.m_bresp != 2'b00);
        if (mar && bus.m_arready) mar = 0;
        if (maw && bus.m_awready) maw = 0;
        if (acc) begin
            mar = 1; maw = 1;
            e_arid = bus.arid; e_araddr = bus.araddr; e_arlen = bus.arlen; e_arburst = bus.arburst;
            e_awid = bus.awid; e_awaddr = bus.awaddr; e_awlen = bus.awlen; e_awburst = bus.awburst;
        end
        mo = mo + int'(acc) - int'(bh);
        if (rst) model_reset();

        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] id, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [7:0] len);
        bus.arid = id;  bus.araddr = ra; bus.arlen = len; bus.arburst = 2'b01;
        bus.awid = id;  bus.awaddr = wa; bus.awlen = len; bus.awburst = 2'b01;
    endtask

    task automatic rand_req();
        bus.arid = 5'($urandom); bus.araddr = $urandom; bus.arlen = 8'($urandom); bus.arburst = 2'($urandom);
        bus.awid = 5'($urandom); bus.awaddr = $urandom; bus.awlen = 8'($urandom); bus.awburst = 2'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        bus.atx_vld = 0; bus.m_arready = 0; bus.m_awready = 0;
        bus.m_bvalid = 0; bus.m_bresp = 2'b00; bus.m_bid = '0;
        set_req(5'd0, 32'd0, 32'd0, 8'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_araddr", bus.m_araddr, 32'h0);
        chk("rst_awaddr", bus.m_awaddr, 32'h0);
        chk("rst_rdy",    32'(bus.atx_rdy), 32'd1);
        cyc();

        // 1: single request, both channels ready
        set_req(5'd1, 32'h1000, 32'h2000, 8'd15);
        bus.m_arready = 1; bus.m_awready = 1; bus.atx_vld = 1;
        cyc();
        bus.atx_vld = 0;
        chk("t1_arvalid", 32'(bus.m_arvalid), 32'd1);
        chk("t1_awvalid", 32'(bus.m_awvalid), 32'd1);
        chk("t1_araddr",  bus.m_araddr, 32'h1000);
        cyc();
        chk("t1_arvalid_drop", 32'(bus.m_arvalid), 32'd0);
        chk("t1_ost",          32'(bus.ost_cnt),   32'd1);
        chk("t1_rdy",          32'(bus.atx_rdy),   32'd1);

        // 2: AW stalled for 5 cycles
        set_req(5'd2, 32'h3000, 32'h2000, 8'd7);
        bus.m_awready = 0; bus.atx_vld = 1;
        cyc();
        bus.atx_vld = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_awvalid", 32'(bus.m_awvalid), 32'd1);
            chk("t2_awaddr",  bus.m_awaddr, 32'h2000);
            chk("t2_rdy",     32'(bus.atx_rdy), 32'd0);
            cyc();
        end
        bus.m_awready = 1;
        cyc();
        chk("t2_rdy_after", 32'(bus.atx_rdy), 32'd1);

        // 3: fill to OST_MAX, then one B
        for (int i = 0; i < 8 && mo < int'(OST_MAX); i++) begin
            rand_req(); bus.atx_vld = 1; cyc();
            bus.atx_vld = 0; cyc();
        end
        chk("t3_ost_full", 32'(bus.ost_cnt), 32'd4);
        chk("t3_rdy_full", 32'(bus.atx_rdy), 32'd0);
        bus.atx_vld = 1; cyc();
        bus.atx_vld = 0;
        chk("t3_no_accept", 32'(bus.m_arvalid), 32'd0);
        bus.m_bvalid = 1; cyc();
        bus.m_bvalid = 0;
        chk("t3_ost", 32'(bus.ost_cnt),  32'd3);
        chk("t3_done", 32'(bus.atx_done), 32'd1);
        chk("t3_rdy", 32'(bus.atx_rdy),  32'd1);

        // 4: accept and B in the same cycle at ost_cnt=2
        bus.m_bvalid = 1; cyc();
        chk("t4_ost_pre", 32'(bus.ost_cnt), 32'd2);
        rand_req(); bus.atx_vld = 1; cyc();
        bus.atx_vld = 0; bus.m_bvalid = 0;
        chk("t4_ost", 32'(bus.ost_cnt), 32'd2);
        chk("t4_done", 32'(bus.atx_done), 32'd1);
        cyc();
        chk("t4_done_once", 32'(bus.atx_done), 32'd0);

        // 5: drain, B with nothing outstanding, then an error response
        bus.m_bvalid = 1;
        for (int i = 0; i < 8 && mo > 0; i++) cyc();
        repeat (3) begin
            cyc();
            chk("t5_bready0", 32'(bus.m_bready), 32'd0);
            chk("t5_nodone",  32'(bus.atx_done), 32'd0);
        end
        bus.m_bvalid = 0;
        rand_req(); bus.atx_vld = 1; cyc();
        bus.atx_vld = 0; cyc();
        bus.m_bvalid = 1; bus.m_bresp = 2'b10; cyc();
        bus.m_bvalid = 0; bus.m_bresp = 2'b00;
        chk("t5_err",  32'(bus.bresp_err), 32'd1);
        chk("t5_done", 32'(bus.atx_done),  32'd1);
        chk("t5_ost",  32'(bus.ost_cnt),   32'd0);
        cyc();
        chk("t5_err_once", 32'(bus.bresp_err), 32'd0);

        // 6: reset with AR pending and three outstanding
        for (int i = 0; i < 2; i++) begin
            rand_req(); bus.atx_vld = 1; cyc();
            bus.atx_vld = 0; cyc();
        end
        bus.m_arready = 0;
        rand_req(); bus.atx_vld = 1; cyc();
        bus.atx_vld = 0; cyc();
        chk("t6_arvalid_pre", 32'(bus.m_arvalid), 32'd1);
        chk("t6_ost_pre",     32'(bus.ost_cnt),   32'd3);
        rst = 1; cyc();
        rst = 0;
        chk("t6_arvalid", 32'(bus.m_arvalid), 32'd0);
        chk("t6_ost",     32'(bus.ost_cnt),   32'd0);
        chk("t6_rdy",     32'(bus.atx_rdy),   32'd1);
        chk("t6_araddr",  bus.m_araddr,       32'h0);
        cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rand_req();
            bus.atx_vld   = ($urandom_range(0, 1) == 1);
            bus.m_arready = ($urandom_range(0, 9) < 6);
            bus.m_awready = ($urandom_range(0, 9) < 5);
            bus.m_bvalid  = ($urandom_range(0, 9) < 3);
            bus.m_bresp   = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom);
            bus.m_bid     = 5'($urandom);
            rst           = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 0; bus.atx_vld = 0; bus.m_bvalid = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
